// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, fetch buffer entry and fetch FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between imem responses and decode.
// Latency: a pushed entry reaches the head output the cycle after its write edge.
// Backpressure: caller never pushes when full or pops when empty; flush overrides push and pop.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  fetch_entry_t            push_entry,
    input  logic                    pop,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output fetch_entry_t            head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage needs no reset: count gates every consumer of the head.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// MIPS fetch stage: holds the PC, issues single-outstanding imem reads, buffers results for decode.
// Latency: imem_req registered one cycle after the issue decision; instr_valid the cycle after rvalid.
// Backpressure: decode valid/ready; no request is issued unless buffer space is reserved for it.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    input  logic [31:0] redirect_base_pc,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW:0]   occ_next;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          redirect;
    logic          resp_vld;
    logic          push;
    logic          pop;
    logic          issue;
    logic [31:0]   seq_pc;
    logic [31:0]   target_pc;

    assign redirect = branch_taken | jump;
    assign seq_pc   = redirect_base_pc + 32'd4;
    assign target_pc = jump ? {seq_pc[31:28], jump_index, 2'b00}
                            : seq_pc + {{14{branch_imm[15]}}, branch_imm, 2'b00};

    assign resp_vld = (state != IDLE) && imem_rvalid;
    assign push     = (state == WAIT) && imem_rvalid && !redirect;
    assign pop      = instr_valid && instr_ready && !redirect;

    // imem_addr still holds the PC of the single outstanding request.
    assign push_entry = '{pc: imem_addr, instr: imem_rdata};

    assign occ_next = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

    always_comb begin
        issue     = 1'b0;
        state_nxt = state;
        if (!redirect && ((state == IDLE) || resp_vld) && (occ_next < (CW+1)'(DEPTH))) begin
            issue = 1'b1;
        end
        if (redirect) begin
            state_nxt = ((state != IDLE) && !imem_rvalid) ? DRAIN : IDLE;
        end else if (issue) begin
            state_nxt = WAIT;
        end else if (resp_vld) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            imem_req <= issue;
            if (redirect) begin
                fetch_pc <= target_pc;
            end else if (issue) begin
                fetch_pc  <= fetch_pc + 32'd4;
                imem_addr <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head       (head)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.instr : 32'd0;
    assign instr_pc    = instr_valid ? head.pc    : 32'd0;
    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];

endmodule
